// File: rtl/vaddr_pkg.sv
// Shared definitions for the video address loop (write and read pointer managers).
//   NUM_BUF_DEF : default number of frame buffers (one-hot pointer width)
//   WR_PTR_RST  : reset value of the write buffer pointer (bit0)
//   RD_PTR_RST  : reset value of the read / last-published pointer (bit1)
//   wr_state_e  : write-side frame FSM states
package vaddr_pkg;

  localparam int NUM_BUF_DEF = 5;
  localparam int WR_PTR_RST  = 1;
  localparam int RD_PTR_RST  = 2;

  typedef enum logic {
    IDLE,
    WRITING
  } wr_state_e;

endpackage

// File: rtl/edge_generator.sv
// Registered single-cycle edge detector.
//   MODE "NORMAL" : pulse on a rising edge of sig; any other value: falling edge.
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   sig    in  level input
//   pulse  out one-cycle pulse, high the cycle after the first sample showing the new level
module edge_generator #(
  parameter string MODE = "NORMAL"
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic pulse
);

  logic sig_q;
  logic sig_qq;
  logic edge_c;

  always_comb begin
    if (MODE == "NORMAL") edge_c = sig_q & ~sig_qq;
    else                  edge_c = ~sig_q & sig_qq;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q  <= 1'b0;
      sig_qq <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sig_q  <= sig;
      sig_qq <= sig_q;
      pulse  <= edge_c;
    end
  end

endmodule

// File: rtl/wr_base_loop.sv
// Write-side frame-buffer pointer manager.
// Owns the one-hot write buffer pointer, counts lines of the frame being written and, on each
// write vsync, either publishes the finished buffer on last_next_point (exact line count) or
// drops it. The next write buffer is chosen by a rotating search that skips the buffer being
// read and the buffer just published.
// Ports:
//   wclk            in  write clock
//   wr_rst_n        in  asynchronous active-low reset
//   vsync           in  write vsync level; rising edge marks a frame boundary
//   line_end        in  one-cycle pulse per written line
//   rd_curr_point   in  read buffer in use (one-hot, already in wclk domain; used as raw mask)
//   wr_curr_point   out buffer currently being written (one-hot)
//   last_next_point out newest complete frame buffer (one-hot)
//   wr_active       out high while writing frames
//   frame_done      out one-cycle pulse: frame published
//   frame_drop      out one-cycle pulse: frame discarded
//   drop_cnt        out saturating count of discarded frames
module wr_base_loop
  import vaddr_pkg::*;
#(
  parameter int NUM_BUF     = NUM_BUF_DEF,
  parameter int FRAME_LINES = 1080,
  parameter int LCNT_W      = 12
) (
  input  logic               wclk,
  input  logic               wr_rst_n,
  input  logic               vsync,
  input  logic               line_end,
  input  logic [NUM_BUF-1:0] rd_curr_point,
  output logic [NUM_BUF-1:0] wr_curr_point,
  output logic [NUM_BUF-1:0] last_next_point,
  output logic               wr_active,
  output logic               frame_done,
  output logic               frame_drop,
  output logic [7:0]         drop_cnt
);

  // Line count saturates one above a full frame so an over-long frame can never wrap back
  // to looking complete.
  localparam logic [LCNT_W-1:0] LCNT_MAX  = LCNT_W'(FRAME_LINES + 1);
  localparam logic [LCNT_W:0]   LINES_OK  = (LCNT_W + 1)'(FRAME_LINES);

  wr_state_e            state_q, state_d;
  logic [LCNT_W-1:0]    line_cnt_q, line_cnt_d;
  logic [LCNT_W:0]      eff_cnt;
  logic [NUM_BUF-1:0]   wr_ptr_d, last_ptr_d;
  logic                 done_d, drop_d;
  logic [7:0]           drop_cnt_d;
  logic                 vs_rise;

  // Rotate left from the current bit and take the first buffer not in excl; the current bit
  // itself is the last candidate. With every bit excluded the pointer holds.
  function automatic logic [NUM_BUF-1:0] next_wr_ptr(input logic [NUM_BUF-1:0] cur,
                                                     input logic [NUM_BUF-1:0] excl);
    logic [NUM_BUF-1:0] cand;
    logic [NUM_BUF-1:0] pick;
    logic               found;
    cand  = cur;
    pick  = cur;
    found = 1'b0;
    for (int k = 1; k <= NUM_BUF; k++) begin
      cand = {cand[NUM_BUF-2:0], cand[NUM_BUF-1]};
      if (!found && ((cand & excl) == '0)) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  edge_generator #(
    .MODE ("NORMAL")
  ) u_vs_edge (
    .clk   (wclk),
    .rst_n (wr_rst_n),
    .sig   (vsync),
    .pulse (vs_rise)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    line_cnt_d = line_cnt_q;
    wr_ptr_d   = wr_curr_point;
    last_ptr_d = last_next_point;
    done_d     = 1'b0;
    drop_d     = 1'b0;
    drop_cnt_d = drop_cnt;
    // A line_end coinciding with vs_rise still belongs to the frame that is ending.
    eff_cnt    = {1'b0, line_cnt_q} + (LCNT_W + 1)'(line_end);

    case (state_q)
      IDLE: begin
        if (vs_rise) begin
          state_d    = WRITING;
          line_cnt_d = '0;
        end
      end
      WRITING: begin
        if (vs_rise) begin
          if (eff_cnt == LINES_OK) begin
            last_ptr_d = wr_curr_point;
            done_d     = 1'b1;
          end else begin
            drop_d = 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt_d = drop_cnt + 8'd1;
          end
          // Exclusion uses the freshly published pointer, so the next write buffer can never
          // overwrite the frame the reader is about to pick up.
          wr_ptr_d   = next_wr_ptr(wr_curr_point, rd_curr_point | last_ptr_d);
          line_cnt_d = '0;
        end else if (line_end && (line_cnt_q != LCNT_MAX)) begin
          line_cnt_d = line_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q         <= IDLE;
      line_cnt_q      <= '0;
      wr_curr_point   <= NUM_BUF'(WR_PTR_RST);
      last_next_point <= NUM_BUF'(RD_PTR_RST);
      frame_done      <= 1'b0;
      frame_drop      <= 1'b0;
      drop_cnt        <= '0;
    end else begin
      state_q         <= state_d;
      line_cnt_q      <= line_cnt_d;
      wr_curr_point   <= wr_ptr_d;
      last_next_point <= last_ptr_d;
      frame_done      <= done_d;
      frame_drop      <= drop_d;
      drop_cnt        <= drop_cnt_d;
    end
  end

  assign wr_active = (state_q == WRITING);

endmodule

// File: tb/tb_wr_base_loop.sv
// Directed bench for wr_base_loop with NUM_BUF=5, FRAME_LINES=4.
module tb_wr_base_loop;

  logic       wclk;
  logic       wr_rst_n;
  logic       vsync;
  logic       line_end;
  logic [4:0] rd_curr_point;
  logic [4:0] wr_curr_point;
  logic [4:0] last_next_point;
  logic       wr_active;
  logic       frame_done;
  logic       frame_drop;
  logic [7:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  wr_base_loop #(
    .NUM_BUF     (5),
    .FRAME_LINES (4),
    .LCNT_W      (12)
  ) dut (
    .wclk            (wclk),
    .wr_rst_n        (wr_rst_n),
    .vsync           (vsync),
    .line_end        (line_end),
    .rd_curr_point   (rd_curr_point),
    .wr_curr_point   (wr_curr_point),
    .last_next_point (last_next_point),
    .wr_active       (wr_active),
    .frame_done      (frame_done),
    .frame_drop      (frame_drop),
    .drop_cnt        (drop_cnt)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) begin
      line_end = 1'b1;
      tick();
      line_end = 1'b0;
      tick();
    end
  endtask

  // Raise vsync and step to the cycle where the pointer update is visible (2 clocks after the
  // first high sample). same_cycle puts a line_end on the cycle the FSM sees vs_rise.
  task automatic vsync_edge(input bit same_cycle);
    vsync = 1'b0;
    repeat (2) tick();
    vsync = 1'b1;
    tick();
    tick();
    line_end = same_cycle;
    tick();
    line_end = 1'b0;
    vsync    = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic done, input logic drop,
                             input logic [4:0] wr, input logic [4:0] last, input logic [7:0] cnt);
    check({tag, ".done"}, frame_done, done);
    check({tag, ".drop"}, frame_drop, drop);
    check({tag, ".wr"},   wr_curr_point, wr);
    check({tag, ".last"}, last_next_point, last);
    check({tag, ".cnt"},  drop_cnt, cnt);
  endtask

  initial begin
    wr_rst_n      = 1'b0;
    vsync         = 1'b0;
    line_end      = 1'b0;
    rd_curr_point = 5'b00010;
    repeat (2) tick();
    check_frame("reset", 1'b0, 1'b0, 5'b00001, 5'b00010, 8'd0);
    check("reset.active", wr_active, 1'b0);
    wr_rst_n = 1'b1;
    repeat (2) tick();

    // First vsync only arms the write side.
    vsync_edge(1'b0);
    check_frame("arm", 1'b0, 1'b0, 5'b00001, 5'b00010, 8'd0);
    check("arm.active", wr_active, 1'b1);

    // Full frame: publish 00001; next pointer skips the read buffer 00010.
    lines(4);
    vsync_edge(1'b0);
    check_frame("good", 1'b1, 1'b0, 5'b00100, 5'b00001, 8'd0);
    tick();
    check("good.pulse_len", frame_done, 1'b0);

    // Short frame is dropped; last holds.
    lines(3);
    vsync_edge(1'b0);
    check_frame("short", 1'b0, 1'b1, 5'b01000, 5'b00001, 8'd1);

    // Fourth line arrives in the vs_rise cycle.
    lines(3);
    vsync_edge(1'b1);
    check_frame("same", 1'b1, 1'b0, 5'b10000, 5'b01000, 8'd1);

    // Long frame: line count saturates above a full frame.
    lines(6);
    vsync_edge(1'b0);
    check_frame("long", 1'b0, 1'b1, 5'b00001, 5'b01000, 8'd2);

    // Empty frames drive the drop counter into saturation; pointer cycles 00001->00100->10000.
    repeat (253) vsync_edge(1'b0);
    check_frame("sat255", 1'b0, 1'b1, 5'b00100, 5'b01000, 8'd255);
    repeat (5) vsync_edge(1'b0);
    check_frame("sat_hold", 1'b0, 1'b1, 5'b00001, 5'b01000, 8'd255);

    // Build up last=00100, wr=00010 using a multi-bit read mask.
    lines(4);
    vsync_edge(1'b0);
    check_frame("good2", 1'b1, 1'b0, 5'b00100, 5'b00001, 8'd255);
    rd_curr_point = 5'b11001;
    lines(4);
    vsync_edge(1'b0);
    check_frame("mask", 1'b1, 1'b0, 5'b00010, 5'b00100, 8'd255);

    // rd=01000, last=00100, wr=00010 -> 10000.
    rd_curr_point = 5'b01000;
    vsync_edge(1'b0);
    check_frame("rot", 1'b0, 1'b1, 5'b10000, 5'b00100, 8'd255);

    // Every buffer excluded: pointer holds.
    rd_curr_point = 5'b11111;
    vsync_edge(1'b0);
    check_frame("full", 1'b0, 1'b1, 5'b10000, 5'b00100, 8'd255);

    // Asynchronous reset mid-frame.
    rd_curr_point = 5'b00010;
    lines(2);
    line_end = 1'b1;
    wr_rst_n = 1'b0;
    #1;
    check_frame("async", 1'b0, 1'b0, 5'b00001, 5'b00010, 8'd0);
    check("async.active", wr_active, 1'b0);
    line_end = 1'b0;
    tick();
    wr_rst_n = 1'b1;
    tick();
    vsync_edge(1'b0);
    check_frame("rearm", 1'b0, 1'b0, 5'b00001, 5'b00010, 8'd0);
    check("rearm.active", wr_active, 1'b1);
    lines(4);
    vsync_edge(1'b0);
    check_frame("post", 1'b1, 1'b0, 5'b00100, 5'b00001, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
